// File: rtl/flip8_line_scan.sv
// rtl/flip8_line_scan.sv - sequential Othello line scanner: legal-move mask and best move for one 8-cell line
// Optional feature macro: FLIP8_SCAN_BEST_FLIP_EN (keeps the flip mask of the best move on best_flip)
module flip8_line_scan #(
  parameter int TIE_HIGH = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] player,
  input  logic [7:0] opponent,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] legal,
  output logic       any_legal,
  output logic [2:0] best_pos,
  output logic [2:0] best_count,
  output logic [7:0] best_flip
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t     state, state_next;
  logic [7:0] p_q, o_q;
  logic [2:0] pos_q;
  logic [7:0] up_mask, dn_mask, flip;
  logic       up_run, up_hit, dn_run, dn_hit;
  logic [2:0] count;
  logic       take_best;
  logic       accept;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;
  assign any_legal = |legal;

  // Flip evaluation for the current pos: walk opponent runs upward and downward,
  // keeping a run only when it is closed by a player stone inside the line.
  always_comb begin
    up_mask = 8'h00;
    up_run  = 1'b1;
    up_hit  = 1'b0;
    dn_mask = 8'h00;
    dn_run  = 1'b1;
    dn_hit  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > int'(pos_q) && up_run) begin
        if (o_q[i]) begin
          up_mask[i] = 1'b1;
        end else begin
          up_run = 1'b0;
          up_hit = p_q[i];
        end
      end
    end
    for (int i = 7; i >= 0; i--) begin
      if (i < int'(pos_q) && dn_run) begin
        if (o_q[i]) begin
          dn_mask[i] = 1'b1;
        end else begin
          dn_run = 1'b0;
          dn_hit = p_q[i];
        end
      end
    end
    if (p_q[pos_q] | o_q[pos_q]) begin
      flip = 8'h00;
    end else begin
      flip = (up_hit ? up_mask : 8'h00) | (dn_hit ? dn_mask : 8'h00);
    end
  end

  // Flip count and best-move replacement rule (strictly greater, or equal-and-nonzero when ties go high).
  always_comb begin
    count     = 3'($countones(flip));
    take_best = (count > best_count) ||
                ((TIE_HIGH != 0) && (count == best_count) && (count != 3'd0));
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: accept in IDLE, eight scan cycles, hold in DONE until consumed.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SCAN;
      SCAN:    if (pos_q == 3'd7) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Line capture, pos counter and result accumulation.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p_q        <= 8'h00;
      o_q        <= 8'h00;
      pos_q      <= 3'd0;
      legal      <= 8'h00;
      best_pos   <= 3'd0;
      best_count <= 3'd0;
    end else if (accept) begin
      p_q        <= player;
      o_q        <= opponent & ~player;
      pos_q      <= 3'd0;
      legal      <= 8'h00;
      best_pos   <= 3'd0;
      best_count <= 3'd0;
    end else if (state == SCAN) begin
      legal[pos_q] <= |flip;
      if (take_best) begin
        best_pos   <= pos_q;
        best_count <= count;
      end
      if (pos_q != 3'd7) begin
        pos_q <= pos_q + 3'd1;
      end
    end
  end

`ifdef FLIP8_SCAN_BEST_FLIP_EN
  logic [7:0] best_flip_q;

  // Flip mask of the best move, updated alongside best_pos.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      best_flip_q <= 8'h00;
    end else if (accept) begin
      best_flip_q <= 8'h00;
    end else if (state == SCAN && take_best) begin
      best_flip_q <= flip;
    end
  end

  assign best_flip = best_flip_q;
`else
  assign best_flip = 8'h00;
`endif

endmodule

// File: tb/tb_flip8_line_scan.sv
// tb/tb_flip8_line_scan.sv - directed table-driven bench for flip8_line_scan
module tb_flip8_line_scan;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready, h_in_ready;
  logic [7:0] player, opponent;
  logic       out_valid, h_out_valid;
  logic       out_ready;
  logic [7:0] legal, h_legal;
  logic       any_legal, h_any_legal;
  logic [2:0] best_pos, h_best_pos;
  logic [2:0] best_count, h_best_count;
  logic [7:0] best_flip, h_best_flip;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  flip8_line_scan #(.TIE_HIGH(0)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .player(player), .opponent(opponent), .out_valid(out_valid), .out_ready(out_ready),
    .legal(legal), .any_legal(any_legal), .best_pos(best_pos),
    .best_count(best_count), .best_flip(best_flip)
  );

  flip8_line_scan #(.TIE_HIGH(1)) dut_hi (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(h_in_ready),
    .player(player), .opponent(opponent), .out_valid(h_out_valid), .out_ready(out_ready),
    .legal(h_legal), .any_legal(h_any_legal), .best_pos(h_best_pos),
    .best_count(h_best_count), .best_flip(h_best_flip)
  );

  typedef struct {
    logic [7:0] p;
    logic [7:0] o;
    logic [7:0] legal;
    logic       any;
    logic [2:0] pos;
    logic [2:0] count;
    logic [7:0] flip;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [7:0] exp_bf(input logic [7:0] f);
`ifdef FLIP8_SCAN_BEST_FLIP_EN
    return f;
`else
    return 8'h00 & f;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_and_wait(input logic [7:0] p, input logic [7:0] o);
    logic early;
    @(negedge clock);
    chk("in_ready_idle", 32'(in_ready), 1);
    in_valid = 1'b1;
    player   = p;
    opponent = o;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    chk("in_ready_scan", 32'(in_ready), 0);
    early = 1'b0;
    for (int k = 1; k < 8; k++) begin
      @(posedge clock);
      #1;
      if (out_valid) early = 1'b1;
    end
    chk("out_valid_early", 32'(early), 0);
    @(posedge clock);
    #1;
    chk("out_valid_at_8", 32'(out_valid), 1);
  endtask

  task automatic check_result(input int idx, input vec_t v);
    chk($sformatf("v%0d_legal", idx), 32'(legal), 32'(v.legal));
    chk($sformatf("v%0d_any_legal", idx), 32'(any_legal), 32'(v.any));
    chk($sformatf("v%0d_best_pos", idx), 32'(best_pos), 32'(v.pos));
    chk($sformatf("v%0d_best_count", idx), 32'(best_count), 32'(v.count));
    chk($sformatf("v%0d_best_flip", idx), 32'(best_flip), 32'(exp_bf(v.flip)));
  endtask

  task automatic handshake();
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    chk("hs_out_valid", 32'(out_valid), 0);
    chk("hs_in_ready", 32'(in_ready), 1);
  endtask

  initial begin
    logic [7:0] hold_legal;
    logic [2:0] hold_pos;
    int acc_cyc[3];
    int n_acc, n_res, ov_cycles;
    int line_idx[3];

    //            player  opp     legal  any  pos   cnt   flip
    vecs[0] = '{8'h01, 8'h06, 8'h08, 1'b1, 3'd3, 3'd2, 8'h06};
    vecs[1] = '{8'h81, 8'h7E, 8'h00, 1'b0, 3'd0, 3'd0, 8'h00};
    vecs[2] = '{8'h41, 8'h22, 8'h14, 1'b1, 3'd2, 3'd1, 8'h02};
    vecs[3] = '{8'h08, 8'h14, 8'h22, 1'b1, 3'd1, 3'd1, 8'h04};
    vecs[4] = '{8'h81, 8'h76, 8'h08, 1'b1, 3'd3, 3'd5, 8'h76};
    vecs[5] = '{8'h01, 8'h07, 8'h08, 1'b1, 3'd3, 3'd2, 8'h06};
    vecs[6] = '{8'h00, 8'h0F, 8'h00, 1'b0, 3'd0, 3'd0, 8'h00};
    vecs[7] = '{8'h01, 8'h7E, 8'h80, 1'b1, 3'd7, 3'd6, 8'h7E};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; player = 8'h00; opponent = 8'h00;
    #12;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_legal", 32'(legal), 0);
    chk("rst_any_legal", 32'(any_legal), 0);
    chk("rst_best_pos", 32'(best_pos), 0);
    chk("rst_best_count", 32'(best_count), 0);
    chk("rst_best_flip", 32'(best_flip), 0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      send_and_wait(vecs[i].p, vecs[i].o);
      check_result(i, vecs[i]);
      if (i == 2) begin
        chk("tie_hi_legal", 32'(h_legal), 32'h14);
        chk("tie_hi_best_pos", 32'(h_best_pos), 4);
        chk("tie_hi_best_count", 32'(h_best_count), 1);
        chk("tie_hi_best_flip", 32'(h_best_flip), 32'(exp_bf(8'h20)));
      end
      handshake();
    end

    // Backpressure: result held in DONE, a competing request is ignored.
    send_and_wait(vecs[0].p, vecs[0].o);
    hold_legal = legal;
    hold_pos   = best_pos;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      in_valid = (k % 2 == 0);
      player   = 8'h08;
      opponent = 8'h14;
      @(posedge clock);
      #1;
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_legal", 32'(legal), 32'h08);
      chk("bp_best_pos", 32'(best_pos), 3);
    end
    @(negedge clock);
    in_valid = 1'b0;
    handshake();
    chk("post_hs_legal_held", 32'(legal), 32'(hold_legal));
    chk("post_hs_pos_held", 32'(best_pos), 32'(hold_pos));

    // Async reset at pos=4 mid-scan, between clock edges.
    @(negedge clock);
    in_valid = 1'b1; player = vecs[0].p; opponent = vecs[0].o;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clock);
    #2;
    chk("partial_legal", 32'(legal), 32'h08);
    reset = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_in_ready", 32'(in_ready), 1);
    chk("arst_legal", 32'(legal), 0);
    chk("arst_any_legal", 32'(any_legal), 0);
    chk("arst_best_pos", 32'(best_pos), 0);
    chk("arst_best_count", 32'(best_count), 0);
    chk("arst_best_flip", 32'(best_flip), 0);
    @(negedge clock);
    reset = 1'b0;
    send_and_wait(vecs[4].p, vecs[4].o);
    check_result(40, vecs[4]);
    handshake();

    // Back-to-back with in_valid held and out_ready high.
    line_idx[0] = 0; line_idx[1] = 4; line_idx[2] = 7;
    n_acc = 0; n_res = 0; ov_cycles = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 45; cyc++) begin
      @(negedge clock);
      if (out_valid) begin
        ov_cycles++;
        if (n_res < 3) begin
          chk($sformatf("b2b%0d_legal", n_res), 32'(legal), 32'(vecs[line_idx[n_res]].legal));
          chk($sformatf("b2b%0d_best_pos", n_res), 32'(best_pos), 32'(vecs[line_idx[n_res]].pos));
          chk($sformatf("b2b%0d_best_count", n_res), 32'(best_count), 32'(vecs[line_idx[n_res]].count));
        end
        n_res++;
      end
      if (in_ready) begin
        if (n_acc < 3) begin
          acc_cyc[n_acc] = cyc;
          player   = vecs[line_idx[n_acc]].p;
          opponent = vecs[line_idx[n_acc]].o;
          in_valid = 1'b1;
          n_acc++;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("b2b_accepts", 32'(n_acc), 3);
    chk("b2b_results", 32'(n_res), 3);
    chk("b2b_out_valid_cycles", 32'(ov_cycles), 3);
    chk("b2b_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 10);
    chk("b2b_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flip8_line_scan.md
Name: flip8_line_scan

Overview:
Sequential move scanner for a single 8-cell Othello line, sitting upstream of the per-line flip evaluation path.
- Accepts a (player, opponent) line over a valid/ready handshake.
- Drives candidate positions 0..7 through an internal flip evaluator, one per cycle, using flip8 semantics: flips on both sides of pos, result in normal bit order.
- Accumulates the legal-move mask and the best move, then presents the result over a valid/ready handshake.

Parameters:
TIE_HIGH, 0, tie-break on equal flip count: 0 = lowest pos wins, 1 = highest pos wins

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  line request valid
in_ready  output  1  block can accept a request (high only in IDLE)
player  input  8  player stones, bit i = cell i
opponent  input  8  opponent stones, bit i = cell i
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
legal  output  8  bit p set iff cell p empty and move at p flips >= 1 stone
any_legal  output  1  OR of legal
best_pos  output  3  legal pos with maximum flip count; 0 if none legal
best_count  output  3  flip count at best_pos (0..6); 0 if none legal
best_flip  output  8  flipped-cell mask for best_pos (see Optional Feature)

Behaviour:
- States: IDLE, SCAN, DONE.
- Reset values: state=IDLE, in_ready=1, out_valid=0; legal, any_legal, best_pos, best_count, best_flip all 0. The pos counter is 0.
- IDLE, accept:
  - Accept on the edge where in_valid & in_ready.
  - Capture P = player and O = opponent & ~player. Overlapping bits count as player stones.
  - Clear the accumulators and go to SCAN with pos=0.
- SCAN, per cycle, evaluate pos combinationally:
  - If P or O is set at pos: flip = 0.
  - Otherwise, for each direction (up toward bit 7, down toward bit 0), walk the contiguous O cells adjacent to pos. They flip only if the first non-O cell exists inside the line and is a P cell.
  - flip = OR of both directions. count = popcount(flip).
- SCAN, accumulate on the clock edge:
  - legal[pos] <= (flip != 0).
  - Replace best when count > best_count, or, with TIE_HIGH=1, when count == best_count and count != 0. With TIE_HIGH=0 only a strictly greater count replaces.
  - On pos=7, go to DONE and set out_valid=1. pos does not wrap into a new scan.
- Latency:
  - out_valid rises 8 clock edges after the accepting edge.
  - A DONE handshake returns to IDLE on the following edge.
  - Minimum request period is 10 cycles.
- DONE:
  - Outputs and out_valid are held stable until out_ready.
  - in_ready is low in SCAN and DONE. in_valid there is ignored and not queued.
  - Handshake edge: out_valid <= 0 and state <= IDLE. Result outputs keep their values until the next accept clears them.
- Reset asserted mid-SCAN or in DONE: immediately return to the reset values. The partial scan is discarded and no out_valid is produced for it.

Optional Feature:
FLIP8_SCAN_BEST_FLIP_EN
- Defined: best_flip carries the flip mask of the current best pos. It updates together with best_pos and is valid while out_valid.
- Undefined: the best_flip register and logic are omitted and the port is tied to 8'h00. All other behaviour is identical.

Test Plan:
- Single move: reset, then accept player=8'h01, opponent=8'h06. Required 8 edges later: out_valid=1, legal=8'h08, any_legal=1, best_pos=3, best_count=2, best_flip=8'h06 (8'h00 without the macro).
- Full line: player=8'h81, opponent=8'h7E. Required: legal=8'h00, any_legal=0, best_pos=0, best_count=0, best_flip=8'h00.
- Tie-break: player=8'h41, opponent=8'h22, giving legal=8'h14 and best_count=1. Required: with TIE_HIGH=0, best_pos=2 and best_flip=8'h02; with TIE_HIGH=1, best_pos=4 and best_flip=8'h20.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid while pulsing in_valid with a different line. Required: outputs stable, in_ready=0, second line not accepted. Raise out_ready: in_ready=1 on the next cycle.
- Async reset: assert reset while pos=4 in SCAN, with no clock edge needed. Required: out_valid=0, in_ready=1, all result outputs 0. A fresh request then completes normally with 8-edge latency.
- Back-to-back: in_valid held high, out_ready=1, three distinct lines. Required: each result appears exactly once, in order, with accepts 10 cycles apart.
